// File: rtl/gpc_pkg.sv
// rtl/gpc_pkg.sv - shared column widths and adder cells for the (2,1,3,5;5) counter
package gpc_pkg;

  localparam int SRC0_W = 5;
  localparam int SRC1_W = 3;
  localparam int SRC2_W = 1;
  localparam int SRC3_W = 2;
  localparam int DST_W  = 5;

  // Full-adder cell: three bits of one weight in, {carry, sum} out.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

endpackage

// File: rtl/gpc_2135_5_core.sv
// rtl/gpc_2135_5_core.sv - combinational full-adder compressor tree for the weighted column sum
module gpc_2135_5_core
  import gpc_pkg::*;
(
  input  logic [SRC0_W-1:0] src0,
  input  logic [SRC1_W-1:0] src1,
  input  logic [SRC2_W-1:0] src2,
  input  logic [SRC3_W-1:0] src3,
  output logic [DST_W-1:0]  sum
);

  // Each fa result is {carry to next weight, sum bit at this weight}.
  logic [1:0] w1_a, w1_b;
  logic [1:0] w2_a, w2_b;
  logic [1:0] w4_a;
  logic [1:0] w8_a;

  // Reduce each column to one bit, rippling carries from weight 1 up to weight 16.
  always_comb begin
    // weight 1: five bits -> dst[0] plus two carries into weight 2
    w1_a = fa(src0[0], src0[1], src0[2]);
    w1_b = fa(w1_a[0], src0[3], src0[4]);
    // weight 2: three inputs plus two carries -> dst[1] plus two carries into weight 4
    w2_a = fa(src1[0], src1[1], src1[2]);
    w2_b = fa(w2_a[0], w1_a[1], w1_b[1]);
    // weight 4: one input plus two carries -> dst[2] plus one carry into weight 8
    w4_a = fa(src2[0], w2_a[1], w2_b[1]);
    // weight 8: two inputs plus one carry -> dst[3] and the weight-16 carry
    w8_a = fa(src3[0], src3[1], w4_a[1]);
    sum  = {w8_a[1], w8_a[0], w4_a[0], w2_b[0], w1_b[0]};
  end

endmodule

// File: rtl/gpc_2135_5.sv
// rtl/gpc_2135_5.sv - registered (2,1,3,5;5) generalized parallel counter
module gpc_2135_5
  import gpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SRC0_W-1:0] src0,
  input  logic [SRC1_W-1:0] src1,
  input  logic [SRC2_W-1:0] src2,
  input  logic [SRC3_W-1:0] src3,
  output logic [DST_W-1:0]  dst,
  output logic              out_valid
);

  logic [DST_W-1:0] sum;
  logic [DST_W-1:0] dst_d, dst_q;
  logic             out_valid_d, out_valid_q;

  gpc_2135_5_core u_core (
    .src0 (src0),
    .src1 (src1),
    .src2 (src2),
    .src3 (src3),
    .sum  (sum)
  );

  // Load the sum only on valid cycles so idle (possibly unknown) inputs never reach dst.
  always_comb begin
    dst_d       = dst_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      dst_d = sum;
    end
  end

  // Result and valid flags, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dst_q       <= dst_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dst       = dst_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gpc_2135_5.sv
// tb/tb_gpc_2135_5.sv - self-checking bench for gpc_2135_5
module tb_gpc_2135_5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] src0;
  logic [2:0] src1;
  logic       src2;
  logic [1:0] src3;
  logic [4:0] dst;
  logic       out_valid;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] s0;
    logic [2:0] s1;
    logic       s2;
    logic [1:0] s3;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[6];

  logic [4:0] model_dst;
  logic       model_valid;

  gpc_2135_5 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .src0      (src0),
    .src1      (src1),
    .src2      (src2),
    .src3      (src3),
    .dst       (dst),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sum(input logic [4:0] a, input logic [2:0] b,
                                         input logic c, input logic [1:0] d);
    int total;
    total = $countones(a) + 2 * $countones(b) + 4 * int'(c) + 8 * $countones(d);
    return total[4:0];
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [2:0] b, input logic c,
                       input logic [1:0] d, input logic v);
    src0     = a;
    src1     = b;
    src2     = c;
    src3     = d;
    in_valid = v;
  endtask

  // Drive at the current negedge, step one cycle, update the reference register and compare.
  task automatic step(input string name, input logic [4:0] a, input logic [2:0] b,
                      input logic c, input logic [1:0] d, input logic v);
    drive(a, b, c, d, v);
    @(negedge clk);
    if (v) model_dst = ref_sum(a, b, c, d);
    model_valid = v;
    check({name, "_dst"}, dst, model_dst);
    check({name, "_vld"}, {4'b0, out_valid}, {4'b0, model_valid});
  endtask

  initial begin
    tbl[0] = '{5'h10, 3'd2, 1'b1, 2'd3, 5'h17};
    tbl[1] = '{5'h0b, 3'd4, 1'b1, 2'd1, 5'h11};
    tbl[2] = '{5'h1b, 3'd7, 1'b1, 2'd0, 5'h0e};
    tbl[3] = '{5'h00, 3'd6, 1'b1, 2'd3, 5'h18};
    tbl[4] = '{5'h00, 3'd0, 1'b0, 2'd0, 5'h00};
    tbl[5] = '{5'h1f, 3'd7, 1'b1, 2'd3, 5'h1f};

    rst_n = 1'b0;
    drive(5'h0, 3'h0, 1'b0, 2'h0, 1'b0);
    model_dst   = 5'h0;
    model_valid = 1'b0;
    #12;
    check("reset_dst", dst, 5'h00);
    check("reset_vld", {4'b0, out_valid}, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // directed and extreme vectors, back to back, against fixed expected sums
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, 1'b1);
      @(negedge clk);
      check($sformatf("table%0d_dst", i), dst, tbl[i].exp);
      check($sformatf("table%0d_vld", i), {4'b0, out_valid}, 5'h01);
    end
    model_dst = tbl[5].exp;

    // hold: idle cycles with random sources keep dst and clear out_valid
    for (int i = 0; i < 5; i++) begin
      drive(5'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'b0);
      @(negedge clk);
      check("hold_dst", dst, 5'h1f);
      check("hold_vld", {4'b0, out_valid}, 5'h00);
    end

    // randomized valid/idle mix against the reference model
    for (int i = 0; i < 300; i++) begin
      step("rand", 5'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    end

    // exhaustive back-to-back sweep of all 2^11 input combinations
    for (int k = 0; k < 2048; k++) begin
      logic [10:0] kv;
      kv = 11'(k);
      step("sweep", kv[4:0], kv[7:5], kv[8], kv[10:9], 1'b1);
    end

    // reset mid-stream acts without a clock edge and discards the pending result
    drive(5'h1f, 3'd7, 1'b1, 2'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dst", dst, 5'h00);
    check("midrst_vld", {4'b0, out_valid}, 5'h00);
    @(posedge clk);
    #1;
    check("rsthold_dst", dst, 5'h00);
    check("rsthold_vld", {4'b0, out_valid}, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_dst   = 5'h00;
    model_valid = 1'b0;
    step("postrst_idle", 5'h15, 3'd5, 1'b1, 2'd2, 1'b0);
    step("postrst_first", 5'h03, 3'd1, 1'b0, 2'd2, 1'b1);
    check("postrst_first_exact", dst, 5'h0c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
